mem_console_subsystem: RTL and testbench

Parametrised successor to the single-port boot RAM. It provides a RAM of configurable width and depth, mirrored across the address space, plus a memory-mapped console window at IO_BASE. CPU writes to the console TX register are buffered in a FIFO and drained to the host/UART side through a valid/ready handshake. It sits between the CPU bus and the console sink.

---
 rtl/mem_console_subsystem.sv | 181 ++++++++++++++++++
 tb/tb_mem_console_subsystem.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_console_subsystem.sv
// mem_console_subsystem: mirrored RAM plus a 4-word memory-mapped console window.
// The window sits at IO_BASE and holds TXDATA (+0), STATUS (+1), CONTROL (+2)
// and a reserved word (+3). TXDATA writes go into a circular TX FIFO, which
// drains to the console sink through a valid/ready handshake.
// Optional build macro: MEM_RDREG_EN. When it is defined, data_out is registered
// and has a 1-cycle read latency. When it is undefined, data_out is combinational.
module mem_console_subsystem #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    RAM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 16'h5A00,
    parameter int                    FIFO_DEPTH = 8,
    parameter string                 INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_overflow
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // Handshake: a byte moves to the sink on a rising edge where tx_valid and
    // tx_ready are both high. tx_valid never depends on tx_ready. tx_data holds
    // steady while the sink stalls. tx_data reads 0 while the FIFO is empty.

    logic [DATA_WIDTH-1:0] ram_q [RAM_DEPTH];
    logic [7:0]            buf_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            shadow_q, shadow_d;

    logic                  io_hit;
    logic [1:0]            io_off;
    logic [RAM_AW-1:0]     ram_idx;
    logic                  pop, push_req, push_accept, push_reject;
    logic                  ctl_wr, flush, clear_ovf;
    logic                  full, empty;
    logic [7:0]            status;
    logic [DATA_WIDTH-1:0] rd_data;

    // Power-up contents: NOP (8'h01) in every word. Reset never touches the RAM.
    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) begin
            ram_q[i] = DATA_WIDTH'(8'h01);
        end
    end

    // Address decode. The IO window wins, and everything else mirrors into the RAM.
    always_comb begin
        io_hit      = (address[ADDR_WIDTH-1:2] == IO_BASE[ADDR_WIDTH-1:2]);
        io_off      = address[1:0];
        ram_idx     = address[RAM_AW-1:0];
        empty       = (count_q == '0);
        full        = (count_q == FULL_CNT);
        pop         = tx_valid & tx_ready;
        push_req    = write_en & io_hit & (io_off == 2'd0);
        ctl_wr      = write_en & io_hit & (io_off == 2'd2);
        flush       = ctl_wr & data_in[1];
        clear_ovf   = ctl_wr & data_in[0];
        // A flush swallows a push in the same cycle without flagging overflow.
        push_accept = push_req & ~flush & (~full | pop);
        push_reject = push_req & ~flush & full & ~pop;
        status      = {5'(count_q), overflow_q, empty, full};
    end

    // FIFO bookkeeping next state. A flush resets everything and overrides a same-cycle pop or push.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        shadow_d   = shadow_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_accept) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                shadow_d = data_in[7:0];
            end
            case ({push_accept, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        if (clear_ovf) begin
            overflow_d = 1'b0;
        end
        // A rejected push beats a same-cycle clear, so overflow stays set.
        if (push_reject) begin
            overflow_d = 1'b1;
        end
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            shadow_q   <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            shadow_q   <= shadow_d;
        end
    end

    // FIFO storage. It needs no reset because the output is gated by the count.
    always_ff @(posedge clock) begin
        if (push_accept) begin
            buf_q[wr_ptr_q] <= data_in[7:0];
        end
    end

    // RAM write port. Writes that land in the IO window never reach the RAM.
    always_ff @(posedge clock) begin
        if (write_en && !io_hit) begin
            ram_q[ram_idx] <= data_in;
        end
    end

    // Sink side: the head byte is shown only while the FIFO holds data.
    always_comb begin
        tx_valid    = ~empty;
        tx_overflow = overflow_q;
        tx_data     = tx_valid ? buf_q[rd_ptr_q] : 8'h00;
    end

    // CPU read mux. IO registers are 8 bits wide and zero-extended.
    always_comb begin
        rd_data = '0;
        if (io_hit) begin
            case (io_off)
                2'd0:    rd_data = DATA_WIDTH'(shadow_q);
                2'd1:    rd_data = DATA_WIDTH'(status);
                default: rd_data = '0;
            endcase
        end else begin
            rd_data = ram_q[ram_idx];
        end
    end

`ifdef MEM_RDREG_EN
    logic [DATA_WIDTH-1:0] data_out_q;

    // Registered read: returns data for the address sampled at the previous edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= rd_data;
        end
    end

    assign data_out = data_out_q;
`else
    assign data_out = rd_data;
`endif

endmodule

// File: tb/tb_mem_console_subsystem.sv
// Testbench for mem_console_subsystem with default parameters.
// The reference model keeps the RAM as an array and the TX FIFO as a queue.
// Expected sink bytes and read data go into queues when stimulus is issued.
// A negedge monitor pops those queues and compares against the DUT.
module tb_mem_console_subsystem;

    logic        clock;
    logic        reset_n;
    logic [15:0] address;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_overflow;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [7:0] ram_m [256];
    logic [7:0] q_m [$];
    logic       ovf_m;
    logic [7:0] shadow_m;

    // Scoreboard queues plus the per-cycle expectations the monitor uses.
    logic [7:0] exp_tx [$];
    logic [7:0] exp_rd [$];
    logic       exp_valid;
    logic       exp_ovf;
    logic       rd_arm;
    logic       rd_arm_q;
    logic       chk_en;
    logic       sink_rdy;

    mem_console_subsystem dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .address    (address),
        .write_en   (write_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_overflow(tx_overflow)
    );

    // Clock and reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) rd_arm_q <= rd_arm;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Read value that the spec rules give for the current model state.
    function automatic logic [7:0] rd_model(input logic [15:0] a);
        int n;
        n = q_m.size();
        if (a[15:2] == 14'h1680) begin
            case (a[1:0])
                2'd0:    return shadow_m;
                2'd1:    return {5'(n), ovf_m, logic'(n == 0), logic'(n == 8)};
                default: return 8'h00;
            endcase
        end
        return ram_m[a[7:0]];
    endfunction

    // Driver: applies one cycle of inputs and advances the model across the next rising edge.
    task automatic step(input logic rst, input logic we, input logic [15:0] a,
                        input logic [7:0] d, input logic rdy, input logic chk);
        logic io;
        logic [1:0] off;
        reset_n   = ~rst;
        write_en  = we;
        address   = a;
        data_in   = d;
        tx_ready  = rdy;
        exp_valid = (q_m.size() != 0);
        exp_ovf   = ovf_m;
        if (chk) begin
            exp_rd.push_back(rd_model(a));
            rd_arm = 1'b1;
        end else begin
            rd_arm = 1'b0;
        end
        if (rst) begin
            q_m.delete();
            ovf_m    = 1'b0;
            shadow_m = 8'h00;
        end else begin
            io  = (a[15:2] == 14'h1680);
            off = a[1:0];
            if (q_m.size() != 0 && rdy) exp_tx.push_back(q_m.pop_front());
            if (we && !io) ram_m[a[7:0]] = d;
            if (we && io && off == 2'd2) begin
                if (d[0]) ovf_m = 1'b0;
                if (d[1]) q_m.delete();
            end
            if (we && io && off == 2'd0) begin
                if (q_m.size() < 8) begin
                    q_m.push_back(d);
                    shadow_m = d;
                end else begin
                    ovf_m = 1'b1;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, a, d, sink_rdy, 1'b0);
    endtask

    task automatic rd(input logic [15:0] a);
        step(1'b0, 1'b0, a, 8'h00, sink_rdy, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 8'h00, sink_rdy, 1'b0);
    endtask

    // Monitor: compares sink handshakes, flags and armed reads.
    always @(negedge clock) begin
        logic armed;
        if (chk_en) begin
            check("tx_valid", {7'b0, tx_valid}, {7'b0, exp_valid});
            check("tx_overflow", {7'b0, tx_overflow}, {7'b0, exp_ovf});
            if (!tx_valid) check("tx_data_idle", tx_data, 8'h00);
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", tx_data, 8'hxx);
                end else begin
                    check("tx_byte", tx_data, exp_tx.pop_front());
                end
            end
`ifdef MEM_RDREG_EN
            armed = rd_arm_q;
`else
            armed = rd_arm;
`endif
            if (armed) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected", data_out, 8'hxx);
                end else begin
                    check("read", data_out, exp_rd.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] msg [10];
        logic [7:0] k;
        logic [15:0] a;
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
        for (int i = 0; i < 256; i++) ram_m[i] = 8'h01;
        ovf_m    = 1'b0;
        shadow_m = 8'h00;
        chk_en   = 1'b0;
        rd_arm   = 1'b0;
        sink_rdy = 1'b0;
        reset_n  = 1'b0;
        write_en = 1'b0;
        address  = 16'h0000;
        data_in  = 8'h00;
        tx_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_en = 1'b1;

        // Reset state and NOP fill
        rd(16'h0000);
        rd(16'h5A01);
        rd(16'h5A00);
        rd(16'h5A02);
        rd(16'h5A03);

        // RAM mirroring
        wr(16'h0105, 8'hAB);
        rd(16'h0005);
        rd(16'h7F05);
        rd(16'h0105);

        // Overflow with a stalled sink, then drain in order
        for (int i = 0; i < 10; i++) wr(16'h5A00, msg[i]);
        rd(16'h5A01);
        rd(16'h5A00);
        sink_rdy = 1'b1;
        idle(10);
        rd(16'h5A01);

        // Full FIFO: push and pop in the same cycle
        wr(16'h5A02, 8'h01);
        sink_rdy = 1'b0;
        for (int i = 0; i < 8; i++) wr(16'h5A00, 8'h30 + 8'(i));
        sink_rdy = 1'b1;
        wr(16'h5A00, 8'h21);
        sink_rdy = 1'b0;
        rd(16'h5A01);
        sink_rdy = 1'b1;
        idle(10);

        // Flush, overflow clear, ignored writes, RAM index 0 untouched
        sink_rdy = 1'b0;
        for (int i = 0; i < 3; i++) wr(16'h5A00, 8'hC0 + 8'(i));
        wr(16'h5A02, 8'h02);
        rd(16'h5A01);
        wr(16'h5A01, 8'hFF);
        wr(16'h5A03, 8'hFF);
        for (int i = 0; i < 9; i++) wr(16'h5A00, 8'hD0 + 8'(i));
        rd(16'h5A01);
        wr(16'h5A02, 8'h01);
        rd(16'h5A01);
        wr(16'h5A02, 8'h02);
        rd(16'h5A01);
        rd(16'h0000);
        rd(16'h5A03);

        // Reset while draining
        for (int i = 0; i < 4; i++) wr(16'h5A00, 8'hE0 + 8'(i));
        sink_rdy = 1'b1;
        idle(2);
        step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        rd(16'h5A01);
        rd(16'h5A00);
        rd(16'h0005);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (((i / 32) % 2) == 1) sink_rdy = ($urandom_range(0, 3) == 0);
            else                     sink_rdy = ($urandom_range(0, 3) != 0);
            k = 8'($urandom_range(0, 19));
            a = 16'($urandom);
            if (k < 7)       wr(16'h5A00, 8'($urandom));
            else if (k == 7) wr(16'h5A02, 8'($urandom_range(0, 3)));
            else if (k < 10) wr(a, 8'($urandom));
            else if (k < 12) wr(16'h5A01 + 16'(2 * $urandom_range(0, 1)), 8'($urandom));
            else if (k < 16) rd(16'h5A00 + 16'($urandom_range(0, 3)));
            else             rd(a);
        end

        // Drain and confirm the scoreboards are empty
        sink_rdy = 1'b1;
        idle(20);
        check("tx_left", 8'(exp_tx.size()), 8'h00);
        check("rd_left", 8'(exp_rd.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
